spi_frame_serializer: RTL and testbench
=======================================

// Module: spi_frame_serializer
// PURPOSE
//  Transmit end of the 4-wire serial link (CLK/DATA/LOAD/STOP) that the redirector receives on RX_*.
//  Accepts 16-bit words from the Cypress slave-FIFO reader (DATA/ENA/LAST).
//  Buffers them and shifts them out MSB first, marking word and message boundaries.
//  One instance per TX channel; the board drives TX_CLK = CLK, so the far end samples on the falling edge.
// PARAMETERS
//  WORD_W      16  serial word width, bits
//  FIFO_DEPTH  16  input word buffer depth, power of 2, >= 4
//  GAP_CYCLES  2   idle cycles after each word (and after STOP), 0..15
// PORTS
//  CLK        in   1       system clock, all logic on rising edge
//  RST        in   1       synchronous reset, active-high
//  DATA       in   WORD_W  word from Cypress reader, byte-swapped upstream
//  ENA        in   1       write strobe, one word per cycle high
//  LAST       in   1       qualifies DATA as final word of message (sampled with ENA)
//  BUSY       out  1       buffer almost full; upstream must stop issuing ENA
//  OVERFLOW   out  1       sticky: a write was dropped because the buffer was full
//  IDLE       out  1       buffer empty and FSM in S_IDLE
//  TX_DATA    out  1       serial data, MSB first
//  TX_LOAD    out  1       high during the cycle carrying bit 0 of every word
//  TX_STOP    out  1       one-cycle pulse after bit 0 of a LAST word
// BEHAVIOUR
//  Reset: TX_DATA=TX_LOAD=TX_STOP=0, BUSY=0, OVERFLOW=0, IDLE=1.
//   Buffer emptied; any partial word is discarded; outputs are 0 on the cycle after RST is sampled.
//  Buffer: FIFO_DEPTH x (WORD_W+1) bits, holds {LAST, DATA}.
//   Push on ENA when count < FIFO_DEPTH.
//   ENA when full: word dropped, count unchanged, OVERFLOW<=1 until RST.
//   Simultaneous push and pop on a full buffer is still a drop; pop-side check uses the registered count.
//   BUSY = (count >= FIFO_DEPTH-1), registered, to cover 1 cycle of upstream latency.
//  FSM states (all outputs registered):
//   S_IDLE:  buffer non-empty -> pop, load shifter, bitcnt<=WORD_W-1, go S_SHIFT.
//   S_SHIFT: TX_DATA = shifter[WORD_W-1], shift left each cycle, bitcnt--.
//    TX_LOAD=1 on the cycle bitcnt==0.
//    Then: LAST tag -> S_STOP; else GAP_CYCLES>0 -> S_GAP; else S_IDLE logic applied same edge (pop next word if present).
//   S_STOP:  TX_STOP=1, TX_DATA=0 for exactly 1 cycle -> S_GAP (or S_IDLE if GAP_CYCLES=0).
//   S_GAP:   TX_DATA=TX_LOAD=TX_STOP=0 for GAP_CYCLES cycles (4-bit counter) -> S_IDLE.
//  Latency: ENA at cycle t into empty idle block -> bit MSB on TX_DATA at t+2, TX_LOAD at t+2+WORD_W-1.
//  Throughput: one word per WORD_W+GAP_CYCLES cycles (+1 after a LAST word).
//   With GAP_CYCLES=0, non-LAST words are gapless.
//  TX_DATA=0 in all non-shift cycles. LAST without preceding words is a 1-word message.
//  IDLE=1 only when count==0 and state==S_IDLE.
// TESTING
//  1 word 0xA5C3 LAST=1 at t0 -> TX_DATA t2..t17 = 1010_0101_1100_0011, TX_LOAD only t17,
//    TX_STOP only t18, IDLE=1 from t21 (GAP=2).
//  3 words 0x0001,0x8000,0xFFFF back-to-back, LAST on third -> TX_LOAD at t17,t35,t53;
//    TX_STOP at t54; no STOP earlier.
//  GAP_CYCLES=0, words 0x1234,0x5678 -> 32 contiguous data bits t2..t33, TX_LOAD t17 and t33.
//  18 consecutive ENA -> BUSY=1 once count reaches 15, 18th word dropped, OVERFLOW=1 and stays;
//    17 words transmitted intact.
//  RST asserted at bit 7 of a word with 3 words buffered -> next cycle all TX_* = 0, IDLE=1,
//    nothing transmitted afterwards.
//  ENA on same cycle as pop with count 1 -> no loss, word order preserved, count stays 1.

Source files
------------

// File: rtl/spi_frame_serializer_if.sv
// Word-input and serial-output bundle for one TX channel of the 4-wire serial link.
// The reader/bench side uses master; the serializer uses slave.
interface spi_frame_serializer_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] data;
    logic              ena;
    logic              last;
    logic              busy;
    logic              overflow;
    logic              idle;
    logic              tx_data;
    logic              tx_load;
    logic              tx_stop;

    modport master (
        output data, ena, last,
        input  busy, overflow, idle, tx_data, tx_load, tx_stop
    );

    modport slave (
        input  data, ena, last,
        output busy, overflow, idle, tx_data, tx_load, tx_stop
    );
endinterface

// File: rtl/spi_frame_serializer.sv
// Buffers {last, data} words from the slave-FIFO reader and shifts them out MSB first.
// It flags the bit-0 cycle of each word on tx_load and the end of a message on tx_stop.
//
//  state   | meaning
//  S_IDLE  | nothing in flight, pop the next word as soon as one is buffered
//  S_SHIFT | driving one word onto tx_data, bitcnt = index of the bit on the line
//  S_STOP  | one-cycle tx_stop pulse after the final word of a message
//  S_GAP   | quiet inter-word gap, gapcnt counts down to the last gap cycle
module spi_frame_serializer #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_frame_serializer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WORD_W);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BUSY_TH_C = CW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_STOP, S_GAP} state_t;

    logic [WORD_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              busy_r;
    logic              overflow_r;

    state_t            state;
    logic [WORD_W-1:0] shifter;
    logic [BW-1:0]     bitcnt;
    logic [3:0]        gapcnt;
    logic              cur_last;
    logic              tx_data_r;
    logic              tx_load_r;
    logic              tx_stop_r;

    logic [WORD_W:0]   head;
    logic              push_ok;
    logic              word_end;
    logic              to_idle;
    logic              pop;

    assign head    = mem[rd_ptr];
    assign push_ok = bus.ena && (count < DEPTH_C);

    // Every state that finishes its work falls through to the idle decision on the
    // same edge, so a buffered word starts without losing a cycle.
    always_comb begin
        word_end = (state == S_SHIFT) && (bitcnt == '0);
        to_idle  = (state == S_IDLE)
                || (word_end && !cur_last && (GAP_CYCLES == 0))
                || ((state == S_STOP) && (GAP_CYCLES == 0))
                || ((state == S_GAP) && (gapcnt == 4'd0));
        pop      = to_idle && (count != '0);
    end

    always_comb begin
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + CW'(1);
        end else if (!push_ok && pop) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {bus.last, bus.data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count  <= count_next;
            busy_r <= (count_next >= BUSY_TH_C);
            if (bus.ena && !push_ok) begin
                overflow_r <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shifter   <= '0;
            bitcnt    <= '0;
            gapcnt    <= '0;
            cur_last  <= 1'b0;
            tx_data_r <= 1'b0;
            tx_load_r <= 1'b0;
            tx_stop_r <= 1'b0;
        end else begin
            tx_data_r <= 1'b0;
            tx_load_r <= 1'b0;
            tx_stop_r <= 1'b0;
            if (pop) begin
                state     <= S_SHIFT;
                tx_data_r <= head[WORD_W-1];
                shifter   <= {head[WORD_W-2:0], 1'b0};
                cur_last  <= head[WORD_W];
                bitcnt    <= BW'(WORD_W - 1);
            end else if (to_idle) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_SHIFT: begin
                        if (!word_end) begin
                            tx_data_r <= shifter[WORD_W-1];
                            shifter   <= {shifter[WORD_W-2:0], 1'b0};
                            bitcnt    <= bitcnt - BW'(1);
                            tx_load_r <= (bitcnt == BW'(1));
                        end else if (cur_last) begin
                            state     <= S_STOP;
                            tx_stop_r <= 1'b1;
                        end else begin
                            state  <= S_GAP;
                            gapcnt <= 4'(GAP_CYCLES - 1);
                        end
                    end
                    S_STOP: begin
                        state  <= S_GAP;
                        gapcnt <= 4'(GAP_CYCLES - 1);
                    end
                    S_GAP: begin
                        gapcnt <= gapcnt - 4'd1;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.overflow = overflow_r;
    assign bus.idle     = (count == '0) && (state == S_IDLE);
    assign bus.tx_data  = tx_data_r;
    assign bus.tx_load  = tx_load_r;
    assign bus.tx_stop  = tx_stop_r;
endmodule

// File: tb/tb_spi_frame_serializer.sv
// Directed bench for spi_frame_serializer: one GAP_CYCLES=2 and one GAP_CYCLES=0 instance,
// per-cycle output logs plus a serial word decoder keyed on tx_load.
module tb_spi_frame_serializer;
    logic clk;
    logic rst;

    spi_frame_serializer_if #(.WORD_W(16)) ifa ();
    spi_frame_serializer_if #(.WORD_W(16)) ifb ();

    spi_frame_serializer #(.WORD_W(16), .FIFO_DEPTH(16), .GAP_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    spi_frame_serializer #(.WORD_W(16), .FIFO_DEPTH(16), .GAP_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [511:0] dt_a, ld_a, st_a, id_a, bz_a, ov_a;
    logic [511:0] dt_b, ld_b;
    logic [15:0]  rx_q_a[$];
    logic [15:0]  rx_q_b[$];
    logic [15:0]  sh_a = '0;
    logic [15:0]  sh_b = '0;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [15:0] exp_word;
        int          exp_load;
        int          exp_stop;
        int          exp_idle;
    } vec_t;

    vec_t vecs[5];

    // Serial word decoder: the 16 bits ending at the tx_load cycle form one word.
    always @(negedge clk) begin
        if (ifa.tx_load) rx_q_a.push_back({sh_a[14:0], ifa.tx_data});
        sh_a = {sh_a[14:0], ifa.tx_data};
        if (ifb.tx_load) rx_q_b.push_back({sh_b[14:0], ifb.tx_data});
        sh_b = {sh_b[14:0], ifb.tx_data};
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (cyc < 512) begin
            dt_a[cyc] = ifa.tx_data;
            ld_a[cyc] = ifa.tx_load;
            st_a[cyc] = ifa.tx_stop;
            id_a[cyc] = ifa.idle;
            bz_a[cyc] = ifa.busy;
            ov_a[cyc] = ifa.overflow;
            dt_b[cyc] = ifb.tx_data;
            ld_b[cyc] = ifb.tx_load;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int last_cyc);
        while (cyc <= last_cyc) step();
    endtask

    task automatic clear_logs();
        dt_a = '0; ld_a = '0; st_a = '0; id_a = '0; bz_a = '0; ov_a = '0;
        dt_b = '0; ld_b = '0;
        rx_q_a.delete();
        rx_q_b.delete();
        cyc = 0;
    endtask

    task automatic do_reset();
        ifa.ena = 1'b0; ifa.last = 1'b0; ifa.data = '0;
        ifb.ena = 1'b0; ifb.last = 1'b0; ifb.data = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    function automatic int first_set(input logic [511:0] v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int ones(input logic [511:0] v, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (v[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] bits_of(input logic [511:0] v, input int from, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[30:0], v[from + i]};
        return r;
    endfunction

    initial begin
        vecs[0] = '{16'hA5C3, 1'b1, 16'hA5C3, 17, 18, 21};
        vecs[1] = '{16'h0001, 1'b0, 16'h0001, 17, -1, 20};
        vecs[2] = '{16'h8000, 1'b1, 16'h8000, 17, 18, 21};
        vecs[3] = '{16'hFFFF, 1'b0, 16'hFFFF, 17, -1, 20};
        vecs[4] = '{16'h3C5A, 1'b1, 16'h3C5A, 17, 18, 21};

        ifa.ena = 1'b0; ifa.last = 1'b0; ifa.data = '0;
        ifb.ena = 1'b0; ifb.last = 1'b0; ifb.data = '0;
        rst = 1'b1;

        // Reset state
        do_reset();
        step();
        check("reset_outs_a", {dt_a[0], ld_a[0], st_a[0], id_a[0], bz_a[0], ov_a[0]}, 6'b000100);
        check("reset_outs_b", {dt_b[0], ld_b[0], ifb.idle}, 3'b001);

        // Single-word vectors on the GAP_CYCLES=2 instance
        for (int v = 0; v < 5; v++) begin
            do_reset();
            ifa.data = vecs[v].data;
            ifa.last = vecs[v].last;
            ifa.ena  = 1'b1;
            step();
            ifa.ena  = 1'b0;
            ifa.last = 1'b0;
            run_to(25);
            check($sformatf("v%0d_word", v), bits_of(dt_a, 2, 16), vecs[v].exp_word);
            check($sformatf("v%0d_data_quiet", v), ones(dt_a, 0, 1) + ones(dt_a, 18, 25), 0);
            check($sformatf("v%0d_load_at", v), first_set(ld_a, 0, 25), vecs[v].exp_load);
            check($sformatf("v%0d_load_count", v), ones(ld_a, 0, 25), 1);
            check($sformatf("v%0d_stop_at", v), first_set(st_a, 0, 25), vecs[v].exp_stop);
            check($sformatf("v%0d_idle_at", v), first_set(id_a, 1, 25), vecs[v].exp_idle);
        end

        // Three-word message, back to back, LAST on the third
        do_reset();
        ifa.ena = 1'b1;
        ifa.data = 16'h0001; step();
        ifa.data = 16'h8000; step();
        ifa.data = 16'hFFFF; ifa.last = 1'b1; step();
        ifa.ena = 1'b0; ifa.last = 1'b0;
        run_to(60);
        check("msg3_load_count", ones(ld_a, 0, 60), 3);
        check("msg3_load1", first_set(ld_a, 0, 60), 17);
        check("msg3_load2", first_set(ld_a, 18, 60), 35);
        check("msg3_load3", first_set(ld_a, 36, 60), 53);
        check("msg3_stop_at", first_set(st_a, 0, 60), 54);
        check("msg3_stop_count", ones(st_a, 0, 60), 1);
        check("msg3_bits_w2", bits_of(dt_a, 20, 16), 16'h8000);
        check("msg3_bits_w3", bits_of(dt_a, 38, 16), 16'hFFFF);
        check("msg3_rx_count", rx_q_a.size(), 3);
        if (rx_q_a.size() == 3)
            check("msg3_rx_order", {rx_q_a[0], rx_q_a[1], rx_q_a[2]}, 48'h0001_8000_FFFF);
        check("msg3_idle_at", first_set(id_a, 3, 60), 57);

        // Gapless pair on the GAP_CYCLES=0 instance
        do_reset();
        ifb.ena = 1'b1;
        ifb.data = 16'h1234; step();
        ifb.data = 16'h5678; step();
        ifb.ena = 1'b0;
        run_to(40);
        check("gap0_bits", bits_of(dt_b, 2, 32), 32'h12345678);
        check("gap0_load_count", ones(ld_b, 0, 40), 2);
        check("gap0_load1", first_set(ld_b, 0, 40), 17);
        check("gap0_load2", first_set(ld_b, 18, 40), 33);
        check("gap0_quiet_after", ones(dt_b, 34, 40), 0);
        check("gap0_rx_count", rx_q_b.size(), 2);
        if (rx_q_b.size() == 2)
            check("gap0_rx_order", {rx_q_b[0], rx_q_b[1]}, 32'h1234_5678);

        // 18 consecutive writes: BUSY at count 15, 18th word dropped, sticky OVERFLOW
        do_reset();
        for (int i = 0; i < 18; i++) begin
            ifa.data = 16'h0100 + 16'(i);
            ifa.ena  = 1'b1;
            step();
        end
        ifa.ena = 1'b0;
        run_to(320);
        check("ovf_busy_first", first_set(bz_a, 0, 40), 16);
        check("ovf_overflow_first", first_set(ov_a, 0, 320), 18);
        check("ovf_overflow_sticky", ones(ov_a, 18, 320), 303);
        check("ovf_busy_released", bz_a[320], 0);
        check("ovf_rx_count", rx_q_a.size(), 17);
        begin
            int bad = 0;
            for (int i = 0; i < rx_q_a.size(); i++)
                if (rx_q_a[i] !== 16'h0100 + 16'(i)) bad++;
            check("ovf_rx_words_bad", bad, 0);
        end

        // RST at bit 7 of the first word with three more buffered (overflow still set)
        clear_logs();
        ifa.ena = 1'b1;
        ifa.data = 16'hAAAA; step();
        ifa.data = 16'h5555; step();
        ifa.data = 16'h1111; step();
        ifa.data = 16'h2222; step();
        ifa.ena = 1'b0;
        run_to(9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_to(80);
        check("rst_pre_overflow", ov_a[0], 1);
        check("rst_bit7_on_line", dt_a[10], 1);
        check("rst_next_cycle", {dt_a[11], ld_a[11], st_a[11], id_a[11], ov_a[11], bz_a[11]}, 6'b000100);
        check("rst_no_data_after", ones(dt_a, 11, 80), 0);
        check("rst_no_load", ones(ld_a, 0, 80) + ones(st_a, 0, 80), 0);
        check("rst_idle_after", ones(id_a, 11, 80), 70);
        check("rst_rx_count", rx_q_a.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
